branch_resolve_ctrl: RTL and testbench

//  In-order tracker/sequencer for predicted branches between fetch and execute.
//  - Queues each predicted branch at fetch; matches resolutions from execute in order.
//  - Drives the branch predictor update interface (branch_pc/branch_outcome/branch_resolved).
//  - On mispredict: flushes younger branches, issues a PC redirect, holds fetch one recovery cycle.

---
 rtl/branch_resolve_ctrl.sv | 162 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// In-order predicted-branch tracker: queues fetch predictions, pops them on execute resolves, drives predictor update and redirect/flush one cycle after the resolve.
// fetch_ready drops when the queue is full and for the single recovery cycle after a mispredict.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_br_valid,
  input  logic [PC_W-1:0]              fetch_br_pc,
  input  logic                         fetch_br_pred,
  output logic                         fetch_ready,
  input  logic                         ex_resolve_valid,
  input  logic                         ex_br_taken,
  input  logic [PC_W-1:0]              ex_br_target,
  output logic                         bp_update_valid,
  output logic [PC_W-1:0]              bp_update_pc,
  output logic                         bp_update_outcome,
  output logic                         redirect_valid,
  output logic [PC_W-1:0]              redirect_pc,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [15:0]                  mispredict_cnt,
  output logic                         resolve_error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        mis_cnt_q, mis_cnt_d;
  logic               err_d;
  logic               bp_valid_d, bp_out_d;
  logic [PC_W-1:0]    bp_pc_d;
  logic               rd_valid_d;
  logic [PC_W-1:0]    rd_pc_d;

  logic [PC_W-1:0]    ent_pc [DEPTH];
  logic [DEPTH-1:0]   ent_pred;

  logic               head_vld;
  logic [PC_W-1:0]    head_pc;
  logic               head_pred;
  logic               alloc_go;
  logic               resolve_go;
  logic               mispredict;

  assign head_vld    = (count_q != '0);
  assign head_pc     = ent_pc[rd_ptr_q];
  assign head_pred   = ent_pred[rd_ptr_q];

  // Ready looks only at registered state; a resolve in the same cycle does not free a slot.
  assign fetch_ready = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH));
  assign alloc_go    = fetch_br_valid && fetch_ready;
  assign resolve_go  = (state_q == ST_RUN) && ex_resolve_valid && head_vld;
  assign mispredict  = resolve_go && (ex_br_taken != head_pred);

  assign outstanding    = count_q;
  assign mispredict_cnt = mis_cnt_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mis_cnt_d  = mis_cnt_q;
    err_d      = resolve_error;
    bp_valid_d = 1'b0;
    bp_pc_d    = bp_update_pc;
    bp_out_d   = bp_update_outcome;
    rd_valid_d = 1'b0;
    rd_pc_d    = redirect_pc;

    case (state_q)
      ST_RUN: begin
        if (ex_resolve_valid && !head_vld) begin
          err_d = 1'b1;
        end
        if (resolve_go) begin
          bp_valid_d = 1'b1;
          bp_pc_d    = head_pc;
          bp_out_d   = ex_br_taken;
        end
        if (mispredict) begin
          // Everything younger than the head is on the wrong path, including this cycle's alloc.
          rd_valid_d = 1'b1;
          rd_pc_d    = ex_br_taken ? ex_br_target : head_pc + PC_W'(4);
          count_d    = '0;
          rd_ptr_d   = wr_ptr_q;
          state_d    = ST_FLUSH;
          if (mis_cnt_q != 16'hFFFF) begin
            mis_cnt_d = mis_cnt_q + 16'd1;
          end
        end else begin
          if (alloc_go) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (resolve_go) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          count_d = count_q + CNT_W'(alloc_go) - CNT_W'(resolve_go);
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= ST_RUN;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      mis_cnt_q         <= '0;
      resolve_error     <= 1'b0;
      bp_update_valid   <= 1'b0;
      bp_update_pc      <= '0;
      bp_update_outcome <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      flush             <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      mis_cnt_q         <= mis_cnt_d;
      resolve_error     <= err_d;
      bp_update_valid   <= bp_valid_d;
      bp_update_pc      <= bp_pc_d;
      bp_update_outcome <= bp_out_d;
      redirect_valid    <= rd_valid_d;
      redirect_pc       <= rd_pc_d;
      flush             <= rd_valid_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (alloc_go && !mispredict) begin
      ent_pc[wr_ptr_q]   <= fetch_br_pc;
      ent_pred[wr_ptr_q] <= fetch_br_pred;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) count_q <= CNT_W'(DEPTH));
  assert property (@(posedge clk) disable iff (!reset) redirect_valid == flush);

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            fetch_br_valid;
  logic [31:0]     fetch_br_pc;
  logic            fetch_br_pred;
  logic            fetch_ready;
  logic            ex_resolve_valid;
  logic            ex_br_taken;
  logic [31:0]     ex_br_target;
  logic            bp_update_valid;
  logic [31:0]     bp_update_pc;
  logic            bp_update_outcome;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            flush;
  logic [2:0]      outstanding;
  logic [15:0]     mispredict_cnt;
  logic            resolve_error;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_br_valid(fetch_br_valid), .fetch_br_pc(fetch_br_pc), .fetch_br_pred(fetch_br_pred),
    .fetch_ready(fetch_ready),
    .ex_resolve_valid(ex_resolve_valid), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc), .bp_update_outcome(bp_update_outcome),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .outstanding(outstanding), .mispredict_cnt(mispredict_cnt), .resolve_error(resolve_error)
  );

  always #5 clk = ~clk;

  // Reference model: list of outstanding branches plus expected registered outputs.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  bit          m_rec;
  bit          e_bp_v, e_bp_out, e_rd_v, e_err;
  logic [31:0] e_bp_pc, e_rd_pc;
  logic [15:0] e_cnt;

  task automatic model_step();
    ent_t h;
    bit   can_alloc;
    bit   mis;
    e_bp_v = 0;
    e_rd_v = 0;
    mis    = 0;
    if (!reset) begin
      mq.delete();
      m_rec = 0; e_cnt = 0; e_err = 0;
      e_bp_pc = 0; e_bp_out = 0; e_rd_pc = 0;
    end else if (m_rec) begin
      m_rec = 0;
    end else begin
      can_alloc = fetch_br_valid && (mq.size() < DEPTH);
      if (ex_resolve_valid) begin
        if (mq.size() == 0) begin
          e_err = 1;
        end else begin
          h = mq.pop_front();
          e_bp_v = 1; e_bp_pc = h.pc; e_bp_out = ex_br_taken;
          if (ex_br_taken != h.pred) begin
            mis = 1; e_rd_v = 1;
            e_rd_pc = ex_br_taken ? ex_br_target : h.pc + 32'd4;
            mq.delete();
            m_rec = 1;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          end
        end
      end
      if (can_alloc && !mis) mq.push_back('{pc: fetch_br_pc, pred: fetch_br_pred});
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_br_valid   = 0;
    ex_resolve_valid = 0;
    ex_br_taken      = 0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic pred);
    fetch_br_valid = 1; fetch_br_pc = pc; fetch_br_pred = pred;
    cycle();
    idle();
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    ex_resolve_valid = 1; ex_br_taken = taken; ex_br_target = tgt;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    reset = 0;
    cycle();
    cycle();
    reset = 1;
    #1;
    n_checks++;
    if ({bp_update_valid, bp_update_outcome, redirect_valid, flush, resolve_error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {bp_update_valid, bp_update_outcome, redirect_valid, flush, resolve_error});
    end
    n_checks++;
    if ({bp_update_pc, redirect_pc} !== 64'd0) begin
      n_fail++; $display("FAIL reset_pcs: got %h %h want 0 0", bp_update_pc, redirect_pc);
    end
    n_checks++;
    if (outstanding !== 3'd0 || mispredict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d %0d want 0 0", outstanding, mispredict_cnt);
    end
    n_checks++;
    if (fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", fetch_ready);
    end
  endtask

  task automatic test_basic();
    alloc(32'h100, 0);
    n_checks++;
    if (outstanding !== 3'd1) begin
      n_fail++; $display("FAIL basic_alloc_outstanding: got %0d want 1", outstanding);
    end
    resolve(0, 32'h0);
    n_checks++;
    if ({bp_update_valid, bp_update_pc, bp_update_outcome} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++; $display("FAIL basic_update: got v=%b pc=%h o=%b want v=1 pc=100 o=0", bp_update_valid, bp_update_pc, bp_update_outcome);
    end
    n_checks++;
    if ({redirect_valid, flush, outstanding} !== {1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL basic_no_redirect: got rv=%b fl=%b out=%0d want 0 0 0", redirect_valid, flush, outstanding);
    end
  endtask

  task automatic test_mispredict_taken();
    alloc(32'h100, 0);
    alloc(32'h200, 1);
    resolve(1, 32'h400);
    n_checks++;
    if ({redirect_valid, flush, redirect_pc} !== {1'b1, 1'b1, 32'h400}) begin
      n_fail++; $display("FAIL mp_redirect: got rv=%b fl=%b pc=%h want 1 1 400", redirect_valid, flush, redirect_pc);
    end
    n_checks++;
    if ({outstanding, fetch_ready, mispredict_cnt} !== {3'd0, 1'b0, 16'd1}) begin
      n_fail++; $display("FAIL mp_state: got out=%0d rdy=%b cnt=%0d want 0 0 1", outstanding, fetch_ready, mispredict_cnt);
    end
    n_checks++;
    if ({bp_update_valid, bp_update_pc, bp_update_outcome} !== {1'b1, 32'h100, 1'b1}) begin
      n_fail++; $display("FAIL mp_update: got v=%b pc=%h o=%b want 1 100 1", bp_update_valid, bp_update_pc, bp_update_outcome);
    end
    // Recovery cycle: both alloc and resolve are ignored without raising the error flag.
    fetch_br_valid = 1; fetch_br_pc = 32'h500; fetch_br_pred = 0;
    ex_resolve_valid = 1; ex_br_taken = 0;
    cycle();
    idle();
    n_checks++;
    if ({outstanding, fetch_ready, redirect_valid, flush, bp_update_valid, resolve_error} !== {3'd0, 1'b1, 4'b0}) begin
      n_fail++; $display("FAIL mp_recovery: got out=%0d rdy=%b rv=%b fl=%b bv=%b err=%b want 0 1 0 0 0 0",
                         outstanding, fetch_ready, redirect_valid, flush, bp_update_valid, resolve_error);
    end
  endtask

  task automatic test_mispredict_not_taken();
    alloc(32'h300, 1);
    resolve(0, 32'hABC0);
    n_checks++;
    if ({redirect_valid, redirect_pc, bp_update_outcome, bp_update_pc} !== {1'b1, 32'h304, 1'b0, 32'h300}) begin
      n_fail++; $display("FAIL nt_redirect: got rv=%b pc=%h o=%b upc=%h want 1 304 0 300", redirect_valid, redirect_pc, bp_update_outcome, bp_update_pc);
    end
    cycle();
    alloc(32'hFFFF_FFFC, 1);
    resolve(0, 32'h0);
    n_checks++;
    if ({redirect_pc, mispredict_cnt} !== {32'h0, 16'd3}) begin
      n_fail++; $display("FAIL nt_wrap: got pc=%h cnt=%0d want 0 3", redirect_pc, mispredict_cnt);
    end
    cycle();
  endtask

  task automatic test_full();
    logic [31:0] exp_pc;
    for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(16 * i), 1'(i));
    n_checks++;
    if ({outstanding, fetch_ready} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_ready: got out=%0d rdy=%b want 4 0", outstanding, fetch_ready);
    end
    alloc(32'hDEAD0, 0);
    n_checks++;
    if (outstanding !== 3'd4) begin
      n_fail++; $display("FAIL full_drop: got out=%0d want 4", outstanding);
    end
    fetch_br_valid = 1; fetch_br_pc = 32'hBEEF0; fetch_br_pred = 0;
    ex_resolve_valid = 1; ex_br_taken = 0;
    cycle();
    idle();
    n_checks++;
    if ({outstanding, bp_update_valid, bp_update_pc} !== {3'd3, 1'b1, 32'h1000}) begin
      n_fail++; $display("FAIL full_alloc_resolve: got out=%0d v=%b pc=%h want 3 1 1000", outstanding, bp_update_valid, bp_update_pc);
    end
    for (int i = 1; i < DEPTH; i++) begin
      resolve(1'(i), 32'h0);
      n_checks++;
      if ({bp_update_valid, bp_update_pc} !== {1'b1, 32'h1000 + 32'(16 * i)}) begin
        n_fail++; $display("FAIL full_drain_%0d: got v=%b pc=%h want 1 %h", i, bp_update_valid, bp_update_pc, 32'h1000 + 32'(16 * i));
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) alloc(32'h2000 + 32'(r * 256 + i * 4), 1'(r ^ i));
      for (int i = 0; i < DEPTH; i++) begin
        resolve(1'(r ^ i), 32'h0);
        exp_pc = 32'h2000 + 32'(r * 256 + i * 4);
        n_checks++;
        if (bp_update_pc !== exp_pc || redirect_valid !== 1'b0) begin
          n_fail++; $display("FAIL wrap_order_r%0d_%0d: got pc=%h rv=%b want %h 0", r, i, bp_update_pc, redirect_valid, exp_pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    alloc(32'h3000, 0);
    alloc(32'h3004, 0);
    for (int i = 0; i < 4; i++) begin
      fetch_br_valid = 1; fetch_br_pc = 32'h3008 + 32'(4 * i); fetch_br_pred = 0;
      ex_resolve_valid = 1; ex_br_taken = 0;
      cycle();
      n_checks++;
      if ({outstanding, bp_update_valid, bp_update_pc} !== {3'd2, 1'b1, 32'h3000 + 32'(4 * i)}) begin
        n_fail++; $display("FAIL b2b_%0d: got out=%0d v=%b pc=%h want 2 1 %h", i, outstanding, bp_update_valid, bp_update_pc, 32'h3000 + 32'(4 * i));
      end
    end
    idle();
    resolve(0, 32'h0);
    resolve(0, 32'h0);
  endtask

  task automatic test_empty_resolve();
    fetch_br_valid = 1; fetch_br_pc = 32'h4000; fetch_br_pred = 0;
    ex_resolve_valid = 1; ex_br_taken = 1;
    cycle();
    idle();
    n_checks++;
    if ({bp_update_valid, resolve_error, outstanding, redirect_valid} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL empty_resolve: got v=%b err=%b out=%0d rv=%b want 0 1 1 0", bp_update_valid, resolve_error, outstanding, redirect_valid);
    end
    resolve(0, 32'h0);
    n_checks++;
    if ({bp_update_valid, resolve_error} !== 2'b11) begin
      n_fail++; $display("FAIL empty_sticky: got v=%b err=%b want 1 1", bp_update_valid, resolve_error);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt;
    reset = 0; cycle(); reset = 1;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      alloc(32'h5000 + 32'(4 * i), 0);
      resolve(1, 32'h6000);
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (mispredict_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL sat_count_%0d: got %0d want %0d", i, mispredict_cnt, exp_cnt);
      end
      cycle();
    end
    // Jump the counter close to its ceiling instead of spending ~200k cycles getting there.
    force dut.mis_cnt_q = 16'hFFFD;
    cycle();
    release dut.mis_cnt_q;
    exp_cnt = 16'hFFFD;
    e_cnt   = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      alloc(32'h7000, 1);
      resolve(0, 32'h0);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (mispredict_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL sat_hold_%0d: got %h want %h", i, mispredict_cnt, exp_cnt);
      end
      cycle();
    end
    alloc(32'h8000, 0);
    alloc(32'h8004, 0);
    ex_resolve_valid = 1; ex_br_taken = 1; ex_br_target = 32'h9000;
    reset = 0;
    cycle();
    idle();
    reset = 1;
    n_checks++;
    if ({bp_update_valid, redirect_valid, flush, outstanding, mispredict_cnt, resolve_error, fetch_ready} !== {3'b0, 3'd0, 16'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid: got bv=%b rv=%b fl=%b out=%0d cnt=%h err=%b rdy=%b want 0 0 0 0 0 0 1",
                         bp_update_valid, redirect_valid, flush, outstanding, mispredict_cnt, resolve_error, fetch_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0] e_out;
    bit         e_rdy;
    reset = 0; cycle(); reset = 1;
    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 199) != 0);
      fetch_br_valid   = ($urandom_range(0, 9) < 7);
      fetch_br_pc      = $urandom() & 32'hFFFF_FFFC;
      fetch_br_pred    = 1'($urandom_range(0, 1));
      ex_resolve_valid = 1'($urandom_range(0, 1));
      ex_br_target     = $urandom() & 32'hFFFF_FFFC;
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) ex_br_taken = mq[0].pred;
      else ex_br_taken = 1'($urandom_range(0, 1));
      cycle();
      e_out = 3'(mq.size());
      e_rdy = !m_rec && (mq.size() < DEPTH);
      n_checks++;
      if (bp_update_valid !== e_bp_v || (e_bp_v && {bp_update_pc, bp_update_outcome} !== {e_bp_pc, e_bp_out})) begin
        n_fail++; $display("FAIL rnd_update@%0d: got v=%b pc=%h o=%b want v=%b pc=%h o=%b", n, bp_update_valid, bp_update_pc, bp_update_outcome, e_bp_v, e_bp_pc, e_bp_out);
      end
      n_checks++;
      if (redirect_valid !== e_rd_v || flush !== e_rd_v || (e_rd_v && redirect_pc !== e_rd_pc)) begin
        n_fail++; $display("FAIL rnd_redirect@%0d: got rv=%b fl=%b pc=%h want %b %b %h", n, redirect_valid, flush, redirect_pc, e_rd_v, e_rd_v, e_rd_pc);
      end
      n_checks++;
      if ({outstanding, fetch_ready, mispredict_cnt, resolve_error} !== {e_out, e_rdy, e_cnt, e_err}) begin
        n_fail++; $display("FAIL rnd_state@%0d: got out=%0d rdy=%b cnt=%0d err=%b want %0d %b %0d %b", n, outstanding, fetch_ready, mispredict_cnt, resolve_error, e_out, e_rdy, e_cnt, e_err);
      end
    end
    reset = 1;
    idle();
  endtask

  initial begin
    reset = 1;
    fetch_br_pc = 0; fetch_br_pred = 0; ex_br_target = 0;
    idle();
    m_rec = 0; e_cnt = 0; e_err = 0;
    test_reset();
    test_basic();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_full();
    test_back_to_back();
    test_empty_resolve();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
